// File: rtl/gyn_wb_arbiter.sv
// gyn_wb_arbiter
// Writeback arbiter for the per-thread register files. ALU results win by
// default; load returns wait in a small FIFO. A starvation counter forces
// one FIFO drain slot after STARVE_LIMIT consecutive ALU wins over a
// non-empty FIFO. Writes to R0, to unimplemented registers or to a
// nonexistent thread are consumed and flagged on wb_drop instead of written.
//
// Optional feature: define GYN_WB_BYPASS_EN to add a read-bypass port that
// exposes the write currently being presented to the register files.
module gyn_wb_arbiter #(
  parameter int NTHREADS     = 4,
  parameter int TID_W        = 2,
  parameter int DW           = 72,
  parameter int AW           = 4,
  parameter int NREGS        = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                alu_valid,
  input  logic [TID_W-1:0]    alu_tid,
  input  logic [AW-1:0]       alu_waddr,
  input  logic [DW-1:0]       alu_wdata,
  output logic                alu_stall,
  input  logic                mem_valid,
  input  logic [TID_W-1:0]    mem_tid,
  input  logic [AW-1:0]       mem_waddr,
  input  logic [DW-1:0]       mem_wdata,
  output logic                mem_ready,
`ifdef GYN_WB_BYPASS_EN
  input  logic [TID_W-1:0]    byp_tid,
  input  logic [AW-1:0]       byp_raddr,
  output logic                byp_hit,
  output logic [DW-1:0]       byp_data,
`endif
  output logic [NTHREADS-1:0] wb_wena,
  output logic [AW-1:0]       wb_waddr,
  output logic [DW-1:0]       wb_wdata,
  output logic                wb_drop
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  // One-hot thread decode; all-zero means the thread id does not exist.
  function automatic logic [NTHREADS-1:0] tid_onehot(input logic [TID_W-1:0] tid);
    logic [NTHREADS-1:0] oh;
    for (int i = 0; i < NTHREADS; i++) begin
      oh[i] = (tid == TID_W'(i));
    end
    return oh;
  endfunction

  // Legal destination: never R0, never beyond the implemented registers.
  function automatic logic addr_ok(input logic [AW-1:0] waddr);
    return (waddr != {AW{1'b0}}) && (int'(waddr) < NREGS);
  endfunction

  // Load-return FIFO storage and pointers
  logic [TID_W-1:0]  fifo_tid_r   [FIFO_DEPTH];
  logic [AW-1:0]     fifo_waddr_r [FIFO_DEPTH];
  logic [DW-1:0]     fifo_wdata_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;

  // Arbitration state and registered outputs
  logic [SC_W-1:0]     starve_cnt_r;
  logic                alu_stall_r;
  logic [NTHREADS-1:0] wb_wena_r;
  logic [AW-1:0]       wb_waddr_r;
  logic [DW-1:0]       wb_wdata_r;
  logic                wb_drop_r;

  // Combinational control
  logic                fifo_nempty_s;
  logic                mem_ready_s;
  logic                alu_accept_s;
  logic                enq_s;
  logic                deq_s;
  logic                alu_win_s;
  logic                sel_valid_s;
  logic [TID_W-1:0]    sel_tid_s;
  logic [AW-1:0]       sel_waddr_s;
  logic [DW-1:0]       sel_wdata_s;
  logic [NTHREADS-1:0] sel_oh_s;
  logic                sel_legal_s;
  logic                sel_drop_s;
  logic [SC_W-1:0]     starve_next_s;
  logic                stall_next_s;

  // Ready comes from the pre-edge count and is forced low during reset.
  assign fifo_nempty_s = (count_r != {CNT_W{1'b0}});
  assign mem_ready_s   = !reset && (count_r < CNT_W'(FIFO_DEPTH));
  assign alu_accept_s  = alu_valid && !alu_stall_r;
  assign enq_s         = mem_valid && mem_ready_s;

  // Pick the write source for this cycle: forced drain, ALU, FIFO, idle.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_tid_s   = {TID_W{1'b0}};
    sel_waddr_s = {AW{1'b0}};
    sel_wdata_s = {DW{1'b0}};
    deq_s       = 1'b0;
    alu_win_s   = 1'b0;
    if (alu_stall_r) begin
      if (fifo_nempty_s) begin
        sel_valid_s = 1'b1;
        sel_tid_s   = fifo_tid_r[rd_ptr_r];
        sel_waddr_s = fifo_waddr_r[rd_ptr_r];
        sel_wdata_s = fifo_wdata_r[rd_ptr_r];
        deq_s       = 1'b1;
      end else begin
        sel_valid_s = 1'b0;
      end
    end else if (alu_accept_s) begin
      sel_valid_s = 1'b1;
      sel_tid_s   = alu_tid;
      sel_waddr_s = alu_waddr;
      sel_wdata_s = alu_wdata;
      alu_win_s   = 1'b1;
    end else if (fifo_nempty_s) begin
      sel_valid_s = 1'b1;
      sel_tid_s   = fifo_tid_r[rd_ptr_r];
      sel_waddr_s = fifo_waddr_r[rd_ptr_r];
      sel_wdata_s = fifo_wdata_r[rd_ptr_r];
      deq_s       = 1'b1;
    end else begin
      sel_valid_s = 1'b0;
    end
  end

  assign sel_oh_s    = tid_onehot(sel_tid_s);
  assign sel_legal_s = sel_valid_s && addr_ok(sel_waddr_s) && (sel_oh_s != {NTHREADS{1'b0}});
  assign sel_drop_s  = sel_valid_s && !sel_legal_s;

  // Starvation tracking: the LIMIT-th ALU win over a waiting load stalls the ALU next cycle.
  always_comb begin
    starve_next_s = starve_cnt_r;
    stall_next_s  = 1'b0;
    if (!fifo_nempty_s || deq_s) begin
      starve_next_s = {SC_W{1'b0}};
    end else if (alu_win_s) begin
      if (starve_cnt_r == SC_W'(STARVE_LIMIT - 1)) begin
        starve_next_s = {SC_W{1'b0}};
        stall_next_s  = 1'b1;
      end else begin
        starve_next_s = starve_cnt_r + SC_W'(1);
      end
    end else begin
      starve_next_s = starve_cnt_r;
    end
  end

  // Store accepted load returns; enq_s is already blocked during reset.
  always_ff @(posedge CLK) begin
    if (enq_s) begin
      fifo_tid_r[wr_ptr_r]   <= mem_tid;
      fifo_waddr_r[wr_ptr_r] <= mem_waddr;
      fifo_wdata_r[wr_ptr_r] <= mem_wdata;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (enq_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (deq_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({enq_s, deq_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Starvation counter and the one-cycle ALU stall.
  always_ff @(posedge CLK) begin
    if (reset) begin
      starve_cnt_r <= {SC_W{1'b0}};
      alu_stall_r  <= 1'b0;
    end else begin
      starve_cnt_r <= starve_next_s;
      alu_stall_r  <= stall_next_s;
    end
  end

  // Registered writeback; address/data hold across idle and dropped cycles.
  always_ff @(posedge CLK) begin
    if (reset) begin
      wb_wena_r  <= {NTHREADS{1'b0}};
      wb_waddr_r <= {AW{1'b0}};
      wb_wdata_r <= {DW{1'b0}};
      wb_drop_r  <= 1'b0;
    end else begin
      wb_drop_r <= sel_drop_s;
      if (sel_legal_s) begin
        wb_wena_r  <= sel_oh_s;
        wb_waddr_r <= sel_waddr_s;
        wb_wdata_r <= sel_wdata_s;
      end else begin
        wb_wena_r  <= {NTHREADS{1'b0}};
      end
    end
  end

  assign alu_stall = alu_stall_r;
  assign mem_ready = mem_ready_s;
  assign wb_wena   = wb_wena_r;
  assign wb_waddr  = wb_waddr_r;
  assign wb_wdata  = wb_wdata_r;
  assign wb_drop   = wb_drop_r;

`ifdef GYN_WB_BYPASS_EN
  // Forward the write being presented this cycle, before the regfile holds it.
  logic byp_hit_s;
  assign byp_hit_s = ((tid_onehot(byp_tid) & wb_wena_r) != {NTHREADS{1'b0}}) &&
                     (wb_waddr_r == byp_raddr);
  assign byp_hit   = byp_hit_s;
  assign byp_data  = byp_hit_s ? wb_wdata_r : {DW{1'b0}};
`endif

endmodule

// File: tb/tb_gyn_wb_arbiter.sv
// Directed bench for gyn_wb_arbiter: expected writebacks are queued as
// stimulus is applied and compared one per clock.
module tb_gyn_wb_arbiter;

  logic        CLK = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [1:0]  alu_tid;
  logic [3:0]  alu_waddr;
  logic [71:0] alu_wdata;
  logic        alu_stall;
  logic        mem_valid;
  logic [1:0]  mem_tid;
  logic [3:0]  mem_waddr;
  logic [71:0] mem_wdata;
  logic        mem_ready;
  logic [3:0]  wb_wena;
  logic [3:0]  wb_waddr;
  logic [71:0] wb_wdata;
  logic        wb_drop;
`ifdef GYN_WB_BYPASS_EN
  logic [1:0]  byp_tid;
  logic [3:0]  byp_raddr;
  logic        byp_hit;
  logic [71:0] byp_data;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0]  wena;
    logic [3:0]  waddr;
    logic [71:0] wdata;
    logic        drop;
  } exp_t;
  exp_t sb_q[$];

  always #5 CLK = ~CLK;

  gyn_wb_arbiter dut (
    .CLK       (CLK),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_tid   (alu_tid),
    .alu_waddr (alu_waddr),
    .alu_wdata (alu_wdata),
    .alu_stall (alu_stall),
    .mem_valid (mem_valid),
    .mem_tid   (mem_tid),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
`ifdef GYN_WB_BYPASS_EN
    .byp_tid   (byp_tid),
    .byp_raddr (byp_raddr),
    .byp_hit   (byp_hit),
    .byp_data  (byp_data),
`endif
    .wb_wena   (wb_wena),
    .wb_waddr  (wb_waddr),
    .wb_wdata  (wb_wdata),
    .wb_drop   (wb_drop)
  );

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_wb(input logic [3:0] wena, input logic [3:0] waddr,
                         input logic [71:0] wdata, input logic drop);
    exp_t e;
    e.wena  = wena;
    e.waddr = waddr;
    e.wdata = wdata;
    e.drop  = drop;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic tick_check(input string tag);
    exp_t e;
    tick();
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s: observed output with no expectation queued, expected an entry", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, ".wena"},  72'(wb_wena),  72'(e.wena));
      chk({tag, ".waddr"}, 72'(wb_waddr), 72'(e.waddr));
      chk({tag, ".wdata"}, wb_wdata,      e.wdata);
      chk({tag, ".drop"},  72'(wb_drop),  72'(e.drop));
    end
  endtask

  task automatic drive_alu(input logic v, input logic [1:0] tid, input logic [3:0] a,
                           input logic [71:0] d);
    alu_valid = v;
    alu_tid   = tid;
    alu_waddr = a;
    alu_wdata = d;
  endtask

  task automatic drive_mem(input logic v, input logic [1:0] tid, input logic [3:0] a,
                           input logic [71:0] d);
    mem_valid = v;
    mem_tid   = tid;
    mem_waddr = a;
    mem_wdata = d;
  endtask

  // Absolute time bound for the whole run
  initial begin
    #100000;
    $display("FAIL watchdog: observed run still active, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    drive_alu(1'b0, 2'd0, 4'd0, 72'h0);
    drive_mem(1'b0, 2'd0, 4'd0, 72'h0);
`ifdef GYN_WB_BYPASS_EN
    byp_tid   = 2'd0;
    byp_raddr = 4'd0;
`endif

    // Reset state
    push_wb(4'b0000, 4'd0, 72'h0, 1'b0);
    tick_check("rst");
    chk("rst.stall", 72'(alu_stall), 72'(1'b0));
    chk("rst.ready", 72'(mem_ready), 72'(1'b0));
    reset = 1'b0;
    #1;
    chk("rst.ready_after", 72'(mem_ready), 72'(1'b1));

    // T1: ALU only
    drive_alu(1'b1, 2'd2, 4'd3, 72'hAB);
    push_wb(4'b0100, 4'd3, 72'hAB, 1'b0);
    tick_check("t1");
    drive_alu(1'b0, 2'd0, 4'd0, 72'h0);
    push_wb(4'b0000, 4'd3, 72'hAB, 1'b0);
    tick_check("t1_hold");

    // T2: collision, ALU first, load one cycle later
    drive_alu(1'b1, 2'd0, 4'd1, 72'h11);
    drive_mem(1'b1, 2'd1, 4'd2, 72'h22);
    push_wb(4'b0001, 4'd1, 72'h11, 1'b0);
    tick_check("t2_alu");
    drive_alu(1'b0, 2'd0, 4'd0, 72'h0);
    drive_mem(1'b0, 2'd0, 4'd0, 72'h0);
    push_wb(4'b0010, 4'd2, 72'h22, 1'b0);
    tick_check("t2_mem");
    // Lone load: no pass-through, written two cycles after enqueue
    drive_mem(1'b1, 2'd3, 4'd4, 72'h33);
    push_wb(4'b0000, 4'd2, 72'h22, 1'b0);
    tick_check("t2_lat1");
    drive_mem(1'b0, 2'd0, 4'd0, 72'h0);
    push_wb(4'b1000, 4'd4, 72'h33, 1'b0);
    tick_check("t2_lat2");

    // T4: filter R0, out-of-range, last legal register, first illegal register
    drive_alu(1'b1, 2'd1, 4'd0, 72'hDEAD);
    push_wb(4'b0000, 4'd4, 72'h33, 1'b1);
    tick_check("t4_r0");
    drive_alu(1'b1, 2'd0, 4'd9, 72'hBEEF);
    push_wb(4'b0000, 4'd4, 72'h33, 1'b1);
    tick_check("t4_r9");
    drive_alu(1'b1, 2'd1, 4'd7, 72'h77);
    push_wb(4'b0010, 4'd7, 72'h77, 1'b0);
    tick_check("t4_r7");
    drive_alu(1'b1, 2'd2, 4'd8, 72'h88);
    push_wb(4'b0000, 4'd7, 72'h77, 1'b1);
    tick_check("t4_r8");
    drive_alu(1'b0, 2'd0, 4'd0, 72'h0);
    push_wb(4'b0000, 4'd7, 72'h77, 1'b0);
    tick_check("t4_idle");

    // T3: four loads under a continuous ALU stream, then the forced drain slot
    for (int i = 0; i < 10; i++) begin
      drive_alu(1'b1, 2'd0, 4'd5, 72'h100 + 72'(i));
      if (i < 4) drive_mem(1'b1, 2'd1, 4'(i + 1), 72'h200 + 72'(i));
      else       drive_mem(1'b0, 2'd0, 4'd0, 72'h0);
      if (i < 9) push_wb(4'b0001, 4'd5, 72'h100 + 72'(i), 1'b0);
      else       push_wb(4'b0010, 4'd1, 72'h200, 1'b0);
      tick_check($sformatf("t3_c%0d", i));
      chk($sformatf("t3_stall_c%0d", i), 72'(alu_stall), 72'(i == 8));
      chk($sformatf("t3_ready_c%0d", i), 72'(mem_ready), 72'(!(i >= 3 && i <= 8)));
    end
    drive_alu(1'b0, 2'd0, 4'd0, 72'h0);
    drive_mem(1'b0, 2'd0, 4'd0, 72'h0);
    for (int i = 1; i < 4; i++) begin
      push_wb(4'b0010, 4'(i + 1), 72'h200 + 72'(i), 1'b0);
      tick_check($sformatf("t3_drain%0d", i));
    end
    push_wb(4'b0000, 4'd4, 72'h203, 1'b0);
    tick_check("t3_empty");
    chk("t3_ready_end", 72'(mem_ready), 72'(1'b1));

    // T5: three loads queued behind ALU traffic, then reset discards them
    for (int i = 0; i < 3; i++) begin
      drive_alu(1'b1, 2'd2, 4'd6, 72'h300 + 72'(i));
      drive_mem(1'b1, 2'd3, 4'(i + 1), 72'h400 + 72'(i));
      push_wb(4'b0100, 4'd6, 72'h300 + 72'(i), 1'b0);
      tick_check($sformatf("t5_q%0d", i));
    end
    drive_alu(1'b0, 2'd0, 4'd0, 72'h0);
    drive_mem(1'b0, 2'd0, 4'd0, 72'h0);
    reset = 1'b1;
    push_wb(4'b0000, 4'd0, 72'h0, 1'b0);
    tick_check("t5_rst");
    chk("t5_rst.ready", 72'(mem_ready), 72'(1'b0));
    reset = 1'b0;
    #1;
    chk("t5_ready_after", 72'(mem_ready), 72'(1'b1));
    for (int i = 0; i < 4; i++) begin
      push_wb(4'b0000, 4'd0, 72'h0, 1'b0);
      tick_check($sformatf("t5_quiet%0d", i));
    end

`ifdef GYN_WB_BYPASS_EN
    // T6: bypass of the write being presented
    drive_alu(1'b1, 2'd3, 4'd5, 72'h77);
    push_wb(4'b1000, 4'd5, 72'h77, 1'b0);
    tick_check("t6_wr");
    drive_alu(1'b0, 2'd0, 4'd0, 72'h0);
    byp_tid   = 2'd3;
    byp_raddr = 4'd5;
    #1;
    chk("t6_hit", 72'(byp_hit), 72'(1'b1));
    chk("t6_data", byp_data, 72'h77);
    byp_tid = 2'd2;
    #1;
    chk("t6_miss_tid", 72'(byp_hit), 72'(1'b0));
    chk("t6_miss_data", byp_data, 72'h0);
    byp_tid   = 2'd3;
    byp_raddr = 4'd4;
    #1;
    chk("t6_miss_addr", 72'(byp_hit), 72'(1'b0));
`endif

    chk("sb_drained", 72'(sb_q.size()), 72'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
